// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding core request to APB SETUP/ACCESS master
// with an ACCESS-phase wait-state timeout so unmapped addresses cannot hang the core.
module apb_master_bridge #(
    parameter int                   BUS_WIDTH = 16,
    parameter int                   TIMEOUT   = 255,
    parameter logic [BUS_WIDTH-1:0] ERR_DATA  = 16'hDEAD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic                 req_we,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 req_ack,
    output logic                 busy,
    output logic                 resp_valid,
    output logic [BUS_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [BUS_WIDTH-1:0] M_PADDR,
    output logic                 M_PWRITE,
    output logic                 M_PSELx,
    output logic                 M_PENABLE,
    output logic [BUS_WIDTH-1:0] M_PWDATA,
    input  logic [BUS_WIDTH-1:0] M_PRDATA,
    input  logic                 M_PREADY
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] paddr_q, paddr_d, pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic                 pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d;
    logic                 rvalid_q, rvalid_d, rerr_q, rerr_d;
    logic                 timeout_hit, done;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == LAST);
    // PREADY on the timeout edge takes priority and completes normally
    assign done        = (state_q == ACCESS) && (M_PREADY || timeout_hit);
    assign req_ack     = req && (state_q == IDLE);
    assign busy        = state_q != IDLE;
    assign resp_valid  = rvalid_q;
    assign resp_err    = rerr_q;
    assign resp_rdata  = rdata_q;
    assign M_PADDR     = paddr_q;
    assign M_PWRITE    = pwrite_q;
    assign M_PSELx     = psel_q;
    assign M_PENABLE   = penable_q;
    assign M_PWDATA    = pwdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        rerr_d    = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                state_d  = SETUP;
                paddr_d  = req_addr;
                pwrite_d = req_we;
                pwdata_d = req_wdata;
                psel_d   = 1'b1;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: if (done) begin
                state_d   = IDLE;
                paddr_d   = '0;
                pwdata_d  = '0;
                pwrite_d  = 1'b0;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                rvalid_d  = 1'b1;
                rerr_d    = !M_PREADY;
                rdata_d   = !M_PREADY ? ERR_DATA : (pwrite_q ? '0 : M_PRDATA);
            end else begin
                cnt_d = (cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vector table plus hand sequences for
// back-to-back, busy-ignore and asynchronous reset, with TIMEOUT=4.
module tb_apb_master_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [15:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [15:0] req_wdata = '0;
    logic        req_ack, busy, resp_valid, resp_err;
    logic [15:0] resp_rdata, M_PADDR, M_PWDATA;
    logic        M_PWRITE, M_PSELx, M_PENABLE;
    logic [15:0] M_PRDATA = '0;
    logic        M_PREADY = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(.BUS_WIDTH(16), .TIMEOUT(4), .ERR_DATA(16'hDEAD)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_we(req_we),
        .req_wdata(req_wdata), .req_ack(req_ack), .busy(busy), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .M_PADDR(M_PADDR),
        .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
        .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          waits;
        logic [15:0] prdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one transfer; waits is the ACCESS index where PREADY is driven (99 = never)
    task automatic run_vec(input vec_t v);
        int lat;
        lat = 0;
        @(negedge clk);
        req = 1'b1; req_addr = v.addr; req_we = v.we; req_wdata = v.wdata; M_PREADY = 1'b0;
        #1;
        chk("ack_idle", req_ack, 1);
        chk("busy_idle", busy, 0);
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 2) begin
                req = 1'b1; req_addr = 16'h00FF; req_we = ~v.we; req_wdata = ~v.wdata;
            end else req = 1'b0;
            M_PREADY = (c >= 2) && (c - 2 == v.waits);
            M_PRDATA = v.prdata;
            #1;
            if (resp_valid) begin
                lat = c;
                chk("resp_err", resp_err, v.exp_err);
                chk("resp_rdata", resp_rdata, v.exp_rdata);
                chk("psel_done", M_PSELx, 0);
                chk("penable_done", M_PENABLE, 0);
                chk("paddr_done", M_PADDR, 0);
                chk("busy_done", busy, 0);
            end else begin
                chk("psel", M_PSELx, 1);
                chk("penable", M_PENABLE, c >= 2);
                chk("paddr", M_PADDR, v.addr);
                chk("pwrite", M_PWRITE, v.we);
                chk("pwdata", M_PWDATA, v.wdata);
                chk("busy", busy, 1);
                if (c == 2) chk("ack_busy", req_ack, 0);
            end
        end
        chk("latency", lat, v.exp_lat);
        @(negedge clk);
        req = 1'b0; M_PREADY = 1'b0;
        #1;
        chk("resp_pulse", resp_valid, 0);
        chk("resp_err_clear", resp_err, 0);
        chk("rdata_hold", resp_rdata, v.exp_rdata);
    endtask

    initial begin
        vecs[0] = '{16'h0090, 1'b0, 16'h0000, 0,  16'h1234, 16'h1234, 1'b0, 3};
        vecs[1] = '{16'h00A1, 1'b1, 16'hBEEF, 2,  16'h5555, 16'h0000, 1'b0, 5};
        vecs[2] = '{16'h0010, 1'b0, 16'h0000, 99, 16'h7777, 16'hDEAD, 1'b1, 6};
        vecs[3] = '{16'h0020, 1'b0, 16'h0000, 3,  16'hCAFE, 16'hCAFE, 1'b0, 6};
        vecs[4] = '{16'h0030, 1'b1, 16'h1357, 0,  16'h9999, 16'h0000, 1'b0, 3};
        vecs[5] = '{16'h0044, 1'b0, 16'h0000, 1,  16'hA5A5, 16'hA5A5, 1'b0, 4};

        #1;
        chk("rst_psel", M_PSELx, 0);
        chk("rst_penable", M_PENABLE, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // back-to-back: req held across both transfers
        @(negedge clk);
        req = 1'b1; req_addr = 16'h0080; req_we = 1'b0; req_wdata = 16'h0000; M_PRDATA = 16'h4321;
        #1 chk("b2b_ack1", req_ack, 1);
        @(negedge clk);
        req_addr = 16'h0081; req_we = 1'b1; req_wdata = 16'h2468;
        #1 chk("b2b_ack_setup", req_ack, 0);
        chk("b2b_paddr1", M_PADDR, 16'h0080);
        @(negedge clk);
        M_PREADY = 1'b1;
        @(negedge clk);
        M_PREADY = 1'b0;
        #1;
        chk("b2b_resp1", resp_valid, 1);
        chk("b2b_rdata1", resp_rdata, 16'h4321);
        chk("b2b_ack2", req_ack, 1);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("b2b_psel2", M_PSELx, 1);
        chk("b2b_penable2", M_PENABLE, 0);
        chk("b2b_paddr2", M_PADDR, 16'h0081);
        chk("b2b_pwrite2", M_PWRITE, 1);
        chk("b2b_pwdata2", M_PWDATA, 16'h2468);
        @(negedge clk);
        M_PREADY = 1'b1;
        @(negedge clk);
        M_PREADY = 1'b0;
        #1;
        chk("b2b_resp2", resp_valid, 1);
        chk("b2b_rdata2", resp_rdata, 16'h0000);

        // reset asserted mid-ACCESS, between edges
        @(negedge clk);
        req = 1'b1; req_addr = 16'h0040; req_we = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #1 chk("rst_mid_penable_pre", M_PENABLE, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_psel", M_PSELx, 0);
        chk("rst_mid_penable", M_PENABLE, 0);
        chk("rst_mid_busy", busy, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1 chk("rst_mid_no_resp", resp_valid, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        #1 chk("rst_mid_no_resp_after", resp_valid, 0);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Per-core APB master that converts a single-outstanding core load/store request into an APB SETUP/ACCESS transfer. It sits directly upstream of the shared APB interconnect and drives one slot of that interconnect's S_PADDR/S_PWRITE/S_PSELx/S_PENABLE/S_PWDATA inputs. It consumes the matching S_PRDATA/S_PREADY slot. It adds a wait-state timeout so that an unmapped address (no slave selected, PREADY never returns) cannot hang the core.

Parameters:
BUS_WIDTH, 16, address and data width.
TIMEOUT, 255, maximum ACCESS-phase cycles without PREADY before forced termination; 0 disables the timeout.
ERR_DATA, 16'hDEAD, value returned on resp_rdata for a timed-out transfer.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  1  core request valid (level)
req_addr  input  BUS_WIDTH  request address
req_we  input  1  1 = write, 0 = read
req_wdata  input  BUS_WIDTH  write data
req_ack  output  1  request accepted this cycle (combinational: req & state==IDLE)
busy  output  1  transfer in progress (state != IDLE)
resp_valid  output  1  one-cycle pulse: transfer finished
resp_rdata  output  BUS_WIDTH  read data / ERR_DATA, held until next response
resp_err  output  1  valid with resp_valid: 1 = timeout
M_PADDR  output  BUS_WIDTH  APB address
M_PWRITE  output  1  APB write
M_PSELx  output  1  APB select
M_PENABLE  output  1  APB enable
M_PWDATA  output  BUS_WIDTH  APB write data
M_PRDATA  input  BUS_WIDTH  APB read data
M_PREADY  input  1  APB ready

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, timeout counter=0, all outputs 0 (resp_rdata=0). An in-flight transfer is abandoned with no response. M_PSELx and M_PENABLE drop immediately, without waiting for clk.
- Registered APB outputs. In IDLE, M_PADDR, M_PWDATA, M_PWRITE, M_PSELx and M_PENABLE are all 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If req=1, req_ack=1 and addr/we/wdata are latched.
  - Next cycle is SETUP: M_PSELx=1, M_PENABLE=0, M_PADDR/M_PWRITE/M_PWDATA = latched values.
- SETUP: unconditionally moves to ACCESS (M_PSELx=1, M_PENABLE=1). The timeout counter clears.
- ACCESS, M_PREADY=1 at the edge:
  - Next state is IDLE.
  - resp_valid=1 for exactly one cycle, resp_err=0.
  - resp_rdata = M_PRDATA for a read, 0 for a write.
- ACCESS, M_PREADY=0: stay in ACCESS and increment the counter. Address, data and control are held stable.
- Timeout, when TIMEOUT!=0 and the counter reaches TIMEOUT-1 with M_PREADY still 0:
  - Next state is IDLE.
  - resp_valid=1, resp_err=1, resp_rdata=ERR_DATA.
  - A PREADY arriving on that same edge wins: the transfer completes normally with resp_err=0.
- Latency: req accepted in cycle N → SETUP in N+1 → ACCESS in N+2 → resp_valid in N+3 + wait states. Minimum 3 cycles per transfer.
- Back-to-back: in the resp_valid cycle the state is IDLE, so a req present in that cycle is accepted (req_ack=1). Sustained throughput is 1 transfer per 3 cycles.
- req while busy: ignored, req_ack=0; the core must hold req.
- req_addr/req_we/req_wdata changes after acceptance have no effect on the in-flight transfer.
- resp_err deasserts with resp_valid; resp_rdata holds its value until the next resp_valid.
- Counter width is clog2(TIMEOUT+1), saturating; it never wraps.

Test Plan:
1. Read, zero wait:
   - Stimulus: req=1, addr=16'h0090, we=0, slave returns PREADY=1 with PRDATA=16'h1234 in the first ACCESS cycle.
   - Required: PSELx rises at N+1, PENABLE at N+2; resp_valid at N+3 with rdata=16'h1234, err=0.
2. Write, 2 wait states:
   - Stimulus: addr=16'h00A1, wdata=16'hBEEF, PREADY low for 2 ACCESS cycles.
   - Required: PADDR/PWDATA/PWRITE stable for all 4 APB cycles; resp_valid at N+5 with rdata=0.
3. Timeout:
   - Stimulus: TIMEOUT=4, PREADY never asserted.
   - Required: exactly 4 ACCESS cycles, then PSELx=PENABLE=0; resp_valid=1, err=1, rdata=16'hDEAD.
4. Back-to-back:
   - Stimulus: req held high for two transfers (read 16'h0080, then write 16'h0081).
   - Required: second req_ack in the first transfer's resp_valid cycle; second SETUP one cycle later.
5. Busy/ignore:
   - Stimulus: change req_addr to 16'h00FF during ACCESS.
   - Required: req_ack=0; M_PADDR unchanged.
6. Reset mid-ACCESS:
   - Stimulus: drive reset=0 between clock edges.
   - Required: PSELx/PENABLE go 0 immediately; no resp_valid; after release, the next req completes normally.
